// File: rtl/logic_unit_multicycle_if.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_multicycle_if
// Brief    : start/busy/done handshake and operand/result bus for the
//            multicycle logic unit.
// Revision : 1.0 - initial release
// ============================================================================
interface logic_unit_multicycle_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero
  );
endinterface
`default_nettype wire

// File: rtl/logic_unit_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_multicycle
// Brief    : Bitwise AND/OR/XOR/NOR unit processing SLICE bits per cycle,
//            LSB slice first. Optional macro LOGIC_UNIT_ZERO_FLAG_EN enables
//            the registered result==0 flag.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_multicycle #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  wire                          clk,
  input  wire                          reset,
  logic_unit_multicycle_if.slave       bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  logic [1:0]       r_state;
  logic [1:0]       w_nextState;
  logic [WIDTH-1:0] r_aQ;
  logic [WIDTH-1:0] r_bQ;
  logic [1:0]       r_opQ;
  logic [IDX_W-1:0] r_index;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_resultNext;
  logic [SLICE-1:0] w_sliceA;
  logic [SLICE-1:0] w_sliceB;
  logic [SLICE-1:0] w_sliceOut;
  logic             w_lastSlice;
  logic             w_accept;
  logic             w_busy;
  logic             w_done;

  assign w_lastSlice = (r_index == IDX_W'(NSLICE - 1));
  // DONE accepts a new request exactly like IDLE, giving back-to-back issue.
  assign w_accept    = (r_state != S_RUN) && bus.start;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = S_IDLE;
    case (r_state)
      S_IDLE:  w_nextState = bus.start ? S_RUN : S_IDLE;
      S_RUN:   w_nextState = w_lastSlice ? S_DONE : S_RUN;
      S_DONE:  w_nextState = bus.start ? S_RUN : S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  assign w_sliceA = r_aQ[r_index*SLICE +: SLICE];
  assign w_sliceB = r_bQ[r_index*SLICE +: SLICE];

  always_comb begin
    case (r_opQ)
      OP_AND:  w_sliceOut = w_sliceA & w_sliceB;
      OP_OR:   w_sliceOut = w_sliceA | w_sliceB;
      OP_XOR:  w_sliceOut = w_sliceA ^ w_sliceB;
      default: w_sliceOut = ~(w_sliceA | w_sliceB);
    endcase
  end

  // Result with the current slice merged in; also feeds the zero flag.
  always_comb begin
    w_resultNext = r_result;
    if (r_state == S_RUN) begin
      w_resultNext[r_index*SLICE +: SLICE] = w_sliceOut;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aQ     <= '0;
      r_bQ     <= '0;
      r_opQ    <= 2'b00;
      r_index  <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_aQ     <= bus.a;
      r_bQ     <= bus.b;
      r_opQ    <= bus.op;
      r_index  <= '0;
      r_result <= '0;
    end else if (r_state == S_RUN) begin
      r_result <= w_resultNext;
      r_index  <= w_lastSlice ? '0 : r_index + IDX_W'(1);
    end
  end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero <= 1'b0;
    end else if ((r_state == S_RUN) && w_lastSlice) begin
      r_zero <= (w_resultNext == '0);
    end
  end

  assign bus.zero = r_zero;
`else
  assign bus.zero = 1'b0;
`endif

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;

endmodule
`default_nettype wire
